uop_uart_rx: RTL

Asynchronous serial receiver, 8N1 framing (1 start, 8 data LSB-first, 1 stop, no parity), oversampled by an integer clock-to-bit ratio. It sits at the board serial input and is the receiving end of the team's UART link, paired with the uop_uart_tx transmitter. It presents each received byte as a parallel word with a one-cycle valid strobe and flags framing errors.

---
 rtl/uop_uart_rx_if.sv | 25 ++
 rtl/uop_uart_rx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/uop_uart_rx_if.sv
// Serial receive port: the raw line in, the received byte and its status strobes out.
// The receiver takes the master side; whatever consumes bytes takes the slave side.
interface uop_uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   modport master (
      input  rx,
      output data,
      output valid,
      output frame_err,
      output busy
   );

   modport slave (
      output rx,
      input  data,
      input  valid,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/uop_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling at an integer clock-to-bit ratio.
// Returns to IDLE mid-stop-bit so that a back-to-back start edge is not missed.
//
// state | meaning
// IDLE  | line idle, waiting for a 1->0 edge on the synchronised line
// START | counting to mid start bit, then confirming the line is still low
// DATA  | sampling 8 data bits LSB first, one every CLKS_PER_BIT cycles
// STOP  | sampling the stop bit, then issuing valid or frame_err
module uop_uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic           clk,
   input  logic           reset,
   uop_uart_rx_if.master  bus
);
   localparam int N  = CLKS_PER_BIT;
   localparam int H  = N / 2;
   localparam int CW = $clog2(N);

   localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state;
   logic          rx_meta;
   logic          s;
   logic          s_prev;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          frame_err_q;
   logic          busy_q;

   // Synchroniser and edge flops reset high so reset release never looks like a start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta     <= 1'b1;
         s           <= 1'b1;
         s_prev      <= 1'b1;
         state       <= IDLE;
         cnt         <= '0;
         idx         <= 3'd0;
         shreg       <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rx_meta     <= bus.rx;
         s           <= rx_meta;
         s_prev      <= s;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;

         unique case (state)
            IDLE: begin
               if (s_prev && !s) begin
                  state  <= START;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end

            START: begin
               if (cnt == CNT_HALF) begin
                  if (!s) begin
                     state <= DATA;
                     cnt   <= '0;
                     idx   <= 3'd0;
                  end else begin
                     state  <= IDLE;
                     cnt    <= '0;
                     busy_q <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  shreg[idx] <= s;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            STOP: begin
               if (cnt == CNT_LAST) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  if (s) begin
                     data_q  <= shreg;
                     valid_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            default: begin
               state  <= IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;

endmodule
